// File: rtl/vga_board_renderer.sv
// Game of Life pixel renderer: frame-synchronous shadow board, grid lines and a
// blinking edit cursor, producing 12-bit rgb two clocks after the beam position.
module vga_board_renderer #(
    parameter int H_ORIGIN     = 272,
    parameter int V_ORIGIN     = 83,
    parameter int CELL_LOG2    = 4,
    parameter int V_BLANK_LINE = 515,
    parameter int BLINK_FRAMES = 30
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [9:0]   hCount,
    input  logic [9:0]   vCount,
    input  logic         bright,
    input  logic [255:0] board_i,
    input  logic         board_update_i,
    input  logic [3:0]   cursor_x,
    input  logic [3:0]   cursor_y,
    input  logic         cursor_en,
    output logic [11:0]  rgb,
    output logic         frame_tick_o,
    output logic         board_ack_o
);

    localparam logic [9:0] H_ORG   = 10'(H_ORIGIN);
    localparam logic [9:0] V_ORG   = 10'(V_ORIGIN);
    localparam logic [9:0] V_BLANK = 10'(V_BLANK_LINE);
    localparam logic [9:0] GRID_PX = 10'(16 << CELL_LOG2);
    localparam int         CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_OUTER  = 12'h222;
    localparam logic [11:0] RGB_CURSOR = 12'hFF0;
    localparam logic [11:0] RGB_LINE   = 12'h444;
    localparam logic [11:0] RGB_LIVE   = 12'h0F0;

    // Frame bookkeeping: vblank detection, shadow handshake, blink timer
    logic [9:0]       vcount_prev_q;
    logic             pending_q, pending_d;
    logic [255:0]     shadow_q;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             blink_q, blink_d;
    logic             frame_tick_q, board_ack_q;
    logic             vblank_evt, reload;

    assign vblank_evt = (vCount == V_BLANK) && (vcount_prev_q != V_BLANK);
    assign reload     = vblank_evt && (pending_q || board_update_i);

    always_comb begin
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        blink_d     = blink_q;
        if (vblank_evt) begin
            pending_d = 1'b0;
            if (frame_cnt_q == CNT_LAST) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end else if (board_update_i) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vcount_prev_q <= '0;
            pending_q     <= 1'b0;
            shadow_q      <= '0;
            frame_cnt_q   <= '0;
            blink_q       <= 1'b1;
            frame_tick_q  <= 1'b0;
            board_ack_q   <= 1'b0;
        end else begin
            vcount_prev_q <= vCount;
            pending_q     <= pending_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_q       <= blink_d;
            frame_tick_q  <= vblank_evt;
            board_ack_q   <= reload;
            if (reload) begin
                shadow_q <= board_i;
            end
        end
    end

    // Stage 1: geometry decode of the beam position
    logic [9:0]           dx, dy;
    logic [CELL_LOG2-1:0] dx_lo, dy_lo;
    logic                 inside_d, line_d, border_d;
    logic                 bright_q, inside_q, line_q, border_q;
    logic [3:0]           row_q, col_q;

    assign dx       = hCount - H_ORG;
    assign dy       = vCount - V_ORG;
    assign dx_lo    = dx[CELL_LOG2-1:0];
    assign dy_lo    = dy[CELL_LOG2-1:0];
    assign inside_d = (hCount >= H_ORG) && (vCount >= V_ORG) && (dx < GRID_PX) && (dy < GRID_PX);
    assign line_d   = (dx_lo == '0) || (dy_lo == '0);
    // A cell's border is its first or last pixel row/column.
    assign border_d = line_d || (&dx_lo) || (&dy_lo);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright_q <= 1'b0;
            inside_q <= 1'b0;
            line_q   <= 1'b0;
            border_q <= 1'b0;
            row_q    <= '0;
            col_q    <= '0;
        end else begin
            bright_q <= bright;
            inside_q <= inside_d;
            line_q   <= line_d;
            border_q <= border_d;
            row_q    <= dy[CELL_LOG2+3:CELL_LOG2];
            col_q    <= dx[CELL_LOG2+3:CELL_LOG2];
        end
    end

    // Stage 2: colour selection
    logic        cursor_hit;
    logic [11:0] rgb_d, rgb_q;

    assign cursor_hit = cursor_en && blink_q && (row_q == cursor_y) && (col_q == cursor_x);

    always_comb begin
        rgb_d = RGB_BLACK;
        if (!bright_q) begin
            rgb_d = RGB_BLACK;
        end else if (!inside_q) begin
            rgb_d = RGB_OUTER;
        end else if (cursor_hit && border_q) begin
            rgb_d = RGB_CURSOR;
        end else if (line_q) begin
            rgb_d = RGB_LINE;
        end else if (shadow_q[{row_q, col_q}]) begin
            rgb_d = RGB_LIVE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign rgb          = rgb_q;
    assign frame_tick_o = frame_tick_q;
    assign board_ack_o  = board_ack_q;

endmodule

// File: doc/vga_board_renderer.md
# vga_board_renderer

Pixel renderer for the Game of Life VGA path: consumes the beam position and `bright` from `display_controller` plus the 256-bit board from `Game_of_Life_machine`, and produces the 12-bit `rgb` driven onto `vgaR/vgaG/vgaB`. It holds a frame-synchronous shadow copy of the board, so a generation step never tears mid-frame. It also draws grid lines and a blinking edit cursor. It sits between the machine/display controller and the top-level `rgb` wire.

## Interface
- H_ORIGIN, 272: hCount of the grid's left edge.
- V_ORIGIN, 83: vCount of the grid's top edge.
- CELL_LOG2, 4: log2 of cell size in pixels; grid is 16 cells of 2^CELL_LOG2 px per side.
- V_BLANK_LINE, 515: vCount value whose first appearance marks vertical-blank entry.
- BLINK_FRAMES, 30: frames per cursor blink half-period (≥1).
- clk  in  1  system clock (ClkPort domain).
- reset_n  in  1  asynchronous, active-low reset.
- hCount  in  10  horizontal beam position.
- vCount  in  10  vertical beam position.
- bright  in  1  visible-area flag.
- board_i  in  256  live board; bit index = row*16 + col, row 0 top, col 0 left.
- board_update_i  in  1  one-clk pulse: new generation on board_i is stable.
- cursor_x  in  4  cursor column.
- cursor_y  in  4  cursor row.
- cursor_en  in  1  cursor drawing enable.
- rgb  out  12  {R[3:0],G[3:0],B[3:0]} pixel colour.
- frame_tick_o  out  1  one-clk pulse at vertical-blank entry.
- board_ack_o  out  1  one-clk pulse when shadow board is reloaded.

## Operation
- Vblank entry: registered vCount_prev; event = (vCount == V_BLANK_LINE) && (vCount_prev != V_BLANK_LINE). frame_tick_o pulses the following clk.
- Shadow handshake: board_update_i sets `pending`. On vblank entry with pending (or board_update_i in that same clk), shadow ← board_i, pending ← 0, board_ack_o pulses with frame_tick_o. Multiple updates in one frame collapse to one; the latest board_i at vblank is the one latched.
- Blink: frame counter 0..BLINK_FRAMES-1 advances on each vblank entry; on wrap, blink_phase toggles. The cursor is visible when cursor_en && blink_phase. On reset, blink_phase = 1 (visible).
- Geometry: dx = hCount − H_ORIGIN, dy = vCount − V_ORIGIN (10-bit, unsigned wrap). The pixel is inside the grid when hCount ≥ H_ORIGIN, vCount ≥ V_ORIGIN, dx < 16<<CELL_LOG2, and dy < 16<<CELL_LOG2. col = dx[CELL_LOG2+3:CELL_LOG2], row = dy[...]. A pixel is on a grid line when dx[CELL_LOG2-1:0]==0 or dy[CELL_LOG2-1:0]==0.
- Colour priority, highest first:
  - !bright → 12'h000.
  - outside grid → 12'h222.
  - cursor cell, cursor visible, and pixel on that cell's border (low bits ==0 or all-ones) → 12'hFF0.
  - grid line → 12'h444.
  - shadow[row*16+col] → 12'h0F0.
  - otherwise → 12'h000.

## Timing
- 2-stage pipeline:
  - S1 registers bright, inside, row, col, grid-line flag, and border flag.
  - S2 indexes the shadow and registers rgb.
- rgb reflects the hCount/vCount/bright presented 2 clks earlier.
- Shadow and cursor_* are sampled in S1/S2 as registered state. A shadow reload takes effect starting at the pixel sampled on the clk after the vblank event.
- Reset (async assert, sync release): rgb=0, frame_tick_o=0, board_ack_o=0, shadow=0, pending=0, frame counter=0, vCount_prev=0, pipeline flags=0. Reset mid-frame discards pending; the first vblank after reset reloads only if an update arrives.
- hCount/vCount may hold for several clks (pixel-enable rate); the renderer is rate-agnostic and the vblank event still fires once per frame.

## Test plan
- Reset: hold reset_n=0 with board_i all-ones and bright=1 → rgb=12'h000, frame_tick_o=0, board_ack_o=0. After release with no update, in-grid non-line pixels → 12'h000 (shadow empty).
- Handshake: board_i bit 17 set (row 1, col 1), pulse board_update_i mid-frame → rgb unchanged until vblank. At vCount=515, frame_tick_o and board_ack_o pulse together. Next frame, pixel (H_ORIGIN+24, V_ORIGIN+24) → 12'h0F0 two clks after being presented.
- Collapse/same-cycle: two update pulses in one frame → exactly one board_ack_o. Update pulse coincident with the vblank event → reload happens that frame and pending ends at 0.
- Geometry edges: hCount=H_ORIGIN−1 → 12'h222. hCount=H_ORIGIN → grid line 12'h444. hCount=H_ORIGIN+256 → 12'h222. bright=0 anywhere → 12'h000.
- Cursor blink: cursor_en=1 at (3,5), BLINK_FRAMES=2 → the border of cell (3,5) is 12'hFF0 for frames 0–1, not drawn for frames 2–3, then drawn again. cursor_en=0 → never drawn.
- Latency: step hCount one per clk across a live cell boundary → rgb transitions exactly 2 clks after the input transition.
